// File: rtl/sub_bytes_driver.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_driver
// Brief    : Initiator side of the masked sub-bytes stage handshake. Takes a
//            masked state from the round datapath, fetches one randomness
//            vector, runs the stage until drdy, then holds the substituted
//            state for downstream with a valid/ready handshake.
//            state_t    = 4 words x 4 red_poly_t = 16 bytes (128 bits)
//            red_poly_t = 8 bits; the rng vector is 7 x red_poly_t (56 bits),
//            with element 0 in the most significant byte.
//            Optional macro SB_DRIVER_TIMEOUT_EN adds a RUN stall watchdog
//            with a sticky ERR state.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_driver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         rng_valid,
    output logic         rng_ready,
    input  logic [55:0]  rng_data,
    output logic         sb_active,
    output logic         sb_load_r,
    output logic [55:0]  sb_random_vect,
    output logic [127:0] sb_in,
    input  logic [127:0] sb_out,
    input  logic         sb_drdy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         err
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_CAPT = 3'd3;
    localparam logic [2:0] c_HOLD = 3'd4;
`ifdef SB_DRIVER_TIMEOUT_EN
    localparam logic [2:0] c_ERR  = 3'd5;
`endif

    // Reject watchdog lengths too short for the stage to ever finish.
    if (TIMEOUT_CYCLES < 8) begin : g_timeout_range
        $error("sub_bytes_driver: TIMEOUT_CYCLES must be at least 8");
    end

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic         r_in_ready;
    logic [127:0] r_sb_in;
    logic [127:0] r_out_state;
    logic         w_accept;
    logic         w_load_go;

    assign w_accept  = (r_state == c_IDLE) && in_valid && r_in_ready;
    assign w_load_go = (r_state == c_LOAD) && rng_valid;

`ifdef SB_DRIVER_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_run_cnt;
    logic               w_timeout;

    // RUN-cycle counter: zero on every RUN entry, advances once per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt <= '0;
        end else if (r_state == c_RUN) begin
            r_run_cnt <= r_run_cnt + c_CNT_W'(1);
        end else begin
            r_run_cnt <= '0;
        end
    end

    // drdy in the final allowed cycle still wins over the stall.
    assign w_timeout = (r_state == c_RUN) && !sb_drdy && (r_run_cnt == c_CNT_LAST);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; stray drdy/rng_valid outside RUN/LOAD are ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_next_state = c_LOAD;
            c_LOAD: if (rng_valid) w_next_state = c_RUN;
            c_RUN: begin
                if (sb_drdy) begin
                    w_next_state = c_CAPT;
`ifdef SB_DRIVER_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next_state = c_ERR;
`endif
                end
            end
            c_CAPT: w_next_state = c_HOLD;
            c_HOLD: if (out_ready) w_next_state = c_IDLE;
`ifdef SB_DRIVER_TIMEOUT_EN
            c_ERR:  w_next_state = c_ERR;
`endif
            default: w_next_state = c_IDLE;
        endcase
    end

    // Stage and handshake controls decoded from the current state.
    always_comb begin
        rng_ready      = (r_state == c_LOAD);
        sb_active      = w_load_go || (r_state == c_RUN);
        sb_load_r      = w_load_go;
        sb_random_vect = w_load_go ? rng_data : '0;
        out_valid      = (r_state == c_HOLD);
`ifdef SB_DRIVER_TIMEOUT_EN
        err            = (r_state == c_ERR);
`else
        err            = 1'b0;
`endif
    end

    // in_ready is registered from the next state; stage input and result
    // are captured on acceptance and in CAPT respectively.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b0;
            r_sb_in     <= '0;
            r_out_state <= '0;
        end else begin
            r_in_ready <= (w_next_state == c_IDLE);
            if (w_accept) begin
                r_sb_in <= in_state;
            end
            if (r_state == c_CAPT) begin
                r_out_state <= sb_out;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign sb_in     = r_sb_in;
    assign out_state = r_out_state;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_driver
// Brief    : Directed testbench for sub_bytes_driver. Acts as round
//            controller, randomness source, sub-bytes stage and downstream
//            sink. Timeout vectors apply when SB_DRIVER_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_driver;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         rng_valid = 1'b0;
    logic         rng_ready;
    logic [55:0]  rng_data = '0;
    logic         sb_active;
    logic         sb_load_r;
    logic [55:0]  sb_random_vect;
    logic [127:0] sb_in;
    logic [127:0] sb_out = '0;
    logic         sb_drdy = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         err;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    int t_acc;

    sub_bytes_driver #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_state       (in_state),
        .rng_valid      (rng_valid),
        .rng_ready      (rng_ready),
        .rng_data       (rng_data),
        .sb_active      (sb_active),
        .sb_load_r      (sb_load_r),
        .sb_random_vect (sb_random_vect),
        .sb_in          (sb_in),
        .sb_out         (sb_out),
        .sb_drdy        (sb_drdy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_state      (out_state),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {in_ready, rng_ready, sb_active, sb_load_r, out_valid, err}, 0);
        check({tag, "_sb_in"}, sb_in, 0);
        check({tag, "_rvect"}, sb_random_vect, 0);
        check({tag, "_out_state"}, out_state, 0);
    endtask

    // Present a state in IDLE, wait `stall` LOAD cycles without randomness,
    // then supply it; returns at the negedge of RUN cycle 1.
    task automatic accept(input logic [127:0] st, input logic [55:0] rng, input int stall,
                          output int t0);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_state  = st;
        rng_data  = rng;
        rng_valid = (stall == 0);
        out_ready = 1'b0;
        sb_drdy   = 1'b0;
        @(negedge clk);
        t0       = cyc;
        in_valid = 1'b0;
        in_state = ~st;
        #1;
        check("sb_in_latched", sb_in, st);
        check("in_ready_load", in_ready, 0);
        check("rng_ready_load", rng_ready, 1);
        for (int i = 0; i < stall; i++) begin
            sb_drdy = 1'b1;
            #1;
            check("stall_active", sb_active, 0);
            check("stall_rng_ready", rng_ready, 1);
            check("stall_rvect", sb_random_vect, 0);
            @(negedge clk);
        end
        sb_drdy   = 1'b0;
        rng_valid = 1'b1;
        #1;
        check("load_active", sb_active, 1);
        check("load_r", sb_load_r, 1);
        check("load_rvect", sb_random_vect, {72'h0, rng});
        @(negedge clk);
    endtask

    // Run the stage for n_run cycles (drdy in the last), capture, hold for
    // `hold` cycles of backpressure, then complete the downstream transfer.
    task automatic finish_txn(input logic [127:0] st, input int n_run, input logic [127:0] stage_out,
                              input int hold, input int t0, input int stall);
        for (int r = 1; r <= n_run; r++) begin
            sb_out = ~stage_out;
            #1;
            check("run_active", sb_active, 1);
            check("run_load_r", sb_load_r, 0);
            check("run_rvect", sb_random_vect, 0);
            check("run_sb_in", sb_in, st);
            check("run_err", err, 0);
            if (r == n_run) begin
                sb_drdy = 1'b1;
                sb_out  = stage_out;
            end
            @(negedge clk);
        end
        sb_drdy = 1'b0;
        #1;
        check("capt_active", sb_active, 0);
        check("capt_valid", out_valid, 0);
        @(negedge clk);
        sb_out = ~stage_out;
        #1;
        check("latency", cyc - t0, 2 + stall + n_run);
        check("hold_valid", out_valid, 1);
        check("hold_state", out_state, stage_out);
        check("hold_in_ready", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_state", out_state, stage_out);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("done_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);
        check("done_no_accept", rng_ready, 0);
    endtask

    initial begin
        // Reset with random inputs: every output stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            rng_valid = 1'($urandom);
            rng_data  = {24'($urandom), $urandom};
            sb_out    = {$urandom, $urandom, $urandom, $urandom};
            sb_drdy   = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            check_zero("reset");
        end
        @(negedge clk);
        in_valid  = 1'b0;
        rng_valid = 1'b0;
        sb_drdy   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("in_ready_pre_edge", in_ready, 0);
        @(negedge clk);
        check("in_ready_post_edge", in_ready, 1);

        // Nominal: drdy on RUN cycle 4, 16-byte ramp, substituted state from stage model.
        accept(128'h000102030405060708090a0b0c0d0e0f, 56'h11223344556677, 0, t_acc);
        finish_txn(128'h000102030405060708090a0b0c0d0e0f, 4,
                   128'h63626160676665646b6a69686f6e6d6c, 0, t_acc, 0);

        // Randomness stall of 5 LOAD cycles.
        accept(128'hffeeddccbbaa99887766554433221100, 56'ha5a5a5a5a5a5a5, 5, t_acc);
        finish_txn(128'hffeeddccbbaa99887766554433221100, 2,
                   128'h0123456789abcdeffedcba9876543210, 0, t_acc, 5);

        // Downstream backpressure for 10 cycles.
        accept(128'h0f0e0d0c0b0a09080706050403020100, 56'hdeadbeefcafe01, 0, t_acc);
        finish_txn(128'h0f0e0d0c0b0a09080706050403020100, 1,
                   128'h76ab000000000000ffffffff12345678, 10, t_acc, 0);

`ifdef SB_DRIVER_TIMEOUT_EN
        // No drdy for 8 RUN cycles: sticky error.
        accept(128'h55555555aaaaaaaa55555555aaaaaaaa, 56'h01020304050607, 0, t_acc);
        for (int r = 1; r <= 8; r++) begin
            #1;
            check("to_run_err", err, 0);
            check("to_run_active", sb_active, 1);
            @(negedge clk);
        end
        #1;
        check("to_err", err, 1);
        check("to_handshakes", {in_ready, rng_ready, sb_active, sb_load_r, out_valid}, 0);
        in_valid = 1'b1;
        sb_drdy  = 1'b1;
        @(negedge clk);
        #1;
        check("to_err_sticky", err, 1);
        check("to_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("to_reset_err", err, 0);
        @(negedge clk);
        in_valid = 1'b0;
        sb_drdy  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        // drdy in the final allowed RUN cycle: no error.
        accept(128'h55555555aaaaaaaa55555555aaaaaaaa, 56'h01020304050607, 0, t_acc);
        finish_txn(128'h55555555aaaaaaaa55555555aaaaaaaa, 8,
                   128'hfedcba98765432100011223344556677, 0, t_acc, 0);
`else
        // Without the watchdog RUN waits as long as the stage needs.
        accept(128'h55555555aaaaaaaa55555555aaaaaaaa, 56'h01020304050607, 0, t_acc);
        finish_txn(128'h55555555aaaaaaaa55555555aaaaaaaa, 20,
                   128'hfedcba98765432100011223344556677, 0, t_acc, 0);
`endif

        // Mid-run reset: outputs clear asynchronously, then a clean transfer.
        accept(128'h1111222233334444555566667777888a, 56'h0badf00d0badf0, 0, t_acc);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        accept(128'h99999999888888887777777766666666, 56'h13579bdf2468ac, 0, t_acc);
        finish_txn(128'h99999999888888887777777766666666, 3,
                   128'h3c3c3c3cc3c3c3c35a5a5a5aa5a5a5a5, 0, t_acc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
